// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace capture block.
package trace_pkg;

  localparam int VLEN     = 64;
  localparam int XLEN     = 64;
  localparam int TS_WIDTH = 32;

  typedef enum logic {
    INSTR = 1'b0,
    EXC   = 1'b1
  } trace_kind_e;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_ALL      = 2'd1,
    MODE_EXC_ONLY = 2'd2,
    MODE_NO_DEBUG = 2'd3
  } trace_mode_e;

  typedef struct packed {
    trace_kind_e         kind;
    logic                ovf;
    logic [1:0]          priv;
    logic [TS_WIDTH-1:0] ts;
    logic [VLEN-1:0]     pc;
    logic [31:0]         instr;
    logic [4:0]          rd;
    logic                we;
    logic                fpr;
    logic [XLEN-1:0]     wdata;
  } trace_record_t;

  // Condenses an exception cause into the 32-bit instr slot: interrupt flag plus low cause code.
  function automatic logic [31:0] exc_instr(input logic [XLEN-1:0] cause);
    return {cause[XLEN-1], 25'b0, cause[5:0]};
  endfunction

endpackage

// File: rtl/trace_mwfifo.sv
// Multi-write-port FIFO: up to W compacted entries written per cycle, one read per cycle.
// Not fall-through; the read data is zero while empty.
module trace_mwfifo #(
  parameter int Depth     = 16,
  parameter int W         = 3,
  parameter int DataWidth = 8,
  localparam int AddrW    = $clog2(Depth),
  localparam int PtrW     = AddrW + 1,
  localparam int CntW     = $clog2(W + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CntW-1:0]           wr_cnt_i,
  input  logic [W-1:0][DataWidth-1:0] wr_data_i,
  output logic [PtrW-1:0]           free_o,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [DataWidth-1:0]      rd_data_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [PtrW-1:0]      count;
  logic [AddrW-1:0]     wr_addr [W];
  logic                 pop;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign free_o     = PtrW'(Depth) - count;
  assign rd_valid_o = (count != '0);
  assign pop        = rd_valid_o & rd_ready_i;
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q[AddrW-1:0]] : '0;

  // Slot addresses for this cycle's compacted writes, wrapping around the array.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      wr_addr[i] = AddrW'(wr_ptr_q[AddrW-1:0] + AddrW'(i));
    end
  end

  // Pointer update: the extra MSB separates full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(wr_cnt_i);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage writes for the first wr_cnt_i slots of the compacted vector.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < W; i++) begin
      if (CntW'(i) < wr_cnt_i) begin
        mem_q[wr_addr[i]] <= wr_data_i[i];
      end
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: filters commit/exception events, packs them into
// timestamped records and buffers them; whole cycles are dropped when space runs out.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int NrCommitPorts = 2,
  parameter int Depth         = 16,
  parameter int TsWidth       = 32,
  parameter int DropCntWidth  = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [1:0]                         mode_i,
  input  logic [NrCommitPorts-1:0]           commit_ack_i,
  input  logic [NrCommitPorts-1:0][VLEN-1:0] commit_pc_i,
  input  logic [NrCommitPorts-1:0][31:0]     commit_instr_i,
  input  logic [NrCommitPorts-1:0]           we_gpr_i,
  input  logic [NrCommitPorts-1:0]           we_fpr_i,
  input  logic [NrCommitPorts-1:0][4:0]      waddr_i,
  input  logic [NrCommitPorts-1:0][XLEN-1:0] wdata_i,
  input  logic [1:0]                         priv_lvl_i,
  input  logic                               debug_mode_i,
  input  logic                               ex_valid_i,
  input  logic [XLEN-1:0]                    ex_cause_i,
  input  logic [XLEN-1:0]                    ex_tval_i,
  input  logic [VLEN-1:0]                    ex_pc_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output trace_record_t                      out_record_o,
  output logic [DropCntWidth-1:0]            drop_cnt_o,
  input  logic                               clear_drop_i
);

  localparam int NrSlots  = NrCommitPorts + 1;
  localparam int SlotCntW = $clog2(NrSlots + 1);
  localparam int PtrW     = $clog2(Depth) + 1;
  localparam int RecW     = $bits(trace_record_t);

  trace_mode_e                 mode;
  logic                        instr_en;
  logic                        exc_en;
  logic [NrSlots-1:0]          ev_valid;
  trace_record_t               ev_rec [NrSlots];
  logic [SlotCntW-1:0]         ev_pos [NrSlots];
  logic [SlotCntW-1:0]         run;
  logic [SlotCntW-1:0]         ev_cnt;
  trace_record_t [NrSlots-1:0] slot_rec;
  logic [PtrW-1:0]             fifo_free;
  logic                        admit;
  logic                        drop;
  logic [SlotCntW-1:0]         wr_cnt;
  logic [TsWidth-1:0]          ts_q;
  logic [DropCntWidth-1:0]     drop_cnt_q;
  logic                        ovf_pending_q;
  logic [RecW-1:0]             rd_data;
  logic                        unused_cause;

  assign unused_cause = ^ex_cause_i[XLEN-2:6];

  // Mode filter: decides which event classes may be traced this cycle.
  always_comb begin
    mode     = trace_mode_e'(mode_i);
    instr_en = 1'b0;
    exc_en   = 1'b0;
    case (mode)
      MODE_ALL: begin
        instr_en = 1'b1;
        exc_en   = 1'b1;
      end
      MODE_EXC_ONLY: begin
        exc_en = 1'b1;
      end
      MODE_NO_DEBUG: begin
        instr_en = ~debug_mode_i;
        exc_en   = ~debug_mode_i;
      end
      default: ;
    endcase
  end

  // Record construction: one candidate per commit port plus the exception in the last slot.
  always_comb begin
    for (int k = 0; k < NrCommitPorts; k++) begin
      ev_valid[k]     = instr_en & commit_ack_i[k];
      ev_rec[k]       = '0;
      ev_rec[k].kind  = INSTR;
      ev_rec[k].priv  = priv_lvl_i;
      ev_rec[k].ts    = TS_WIDTH'(ts_q);
      ev_rec[k].pc    = commit_pc_i[k];
      ev_rec[k].instr = commit_instr_i[k];
      ev_rec[k].we    = we_gpr_i[k] | we_fpr_i[k];
      ev_rec[k].fpr   = we_fpr_i[k];
      ev_rec[k].rd    = ev_rec[k].we ? waddr_i[k] : 5'd0;
      ev_rec[k].wdata = ev_rec[k].we ? wdata_i[k] : '0;
    end
    ev_valid[NrCommitPorts]       = exc_en & ex_valid_i;
    ev_rec[NrCommitPorts]         = '0;
    ev_rec[NrCommitPorts].kind    = EXC;
    ev_rec[NrCommitPorts].priv    = priv_lvl_i;
    ev_rec[NrCommitPorts].ts      = TS_WIDTH'(ts_q);
    ev_rec[NrCommitPorts].pc      = ex_pc_i;
    ev_rec[NrCommitPorts].instr   = exc_instr(ex_cause_i);
    ev_rec[NrCommitPorts].wdata   = ex_tval_i;
  end

  // Prefix-sum compaction: eligible events land in consecutive slots in port order.
  always_comb begin
    run = '0;
    for (int j = 0; j < NrSlots; j++) begin
      ev_pos[j] = run;
      run       = run + SlotCntW'(ev_valid[j]);
    end
    ev_cnt = run;
    for (int s = 0; s < NrSlots; s++) begin
      slot_rec[s] = '0;
      for (int j = 0; j < NrSlots; j++) begin
        if (ev_valid[j] && (ev_pos[j] == SlotCntW'(s))) begin
          slot_rec[s] = ev_rec[j];
        end
      end
    end
    slot_rec[0].ovf = ovf_pending_q;
  end

  // All-or-nothing admission against the space free at the start of the cycle.
  assign admit  = (PtrW'(ev_cnt) <= fifo_free);
  assign drop   = (ev_cnt != '0) && !admit;
  assign wr_cnt = admit ? ev_cnt : '0;

  // Free-running timestamp shared by every record written in a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TsWidth'(1);
    end
  end

  // Saturating dropped-cycle counter; a drop in the same cycle as a clear leaves it at 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (clear_drop_i) begin
        drop_cnt_q <= DropCntWidth'(1);
      end else if (!(&drop_cnt_q)) begin
        drop_cnt_q <= drop_cnt_q + DropCntWidth'(1);
      end
    end else if (clear_drop_i) begin
      drop_cnt_q <= '0;
    end
  end

  // Overflow marker: flags the first record written after any dropped cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_pending_q <= 1'b0;
    end else if (drop) begin
      ovf_pending_q <= 1'b1;
    end else if (wr_cnt != '0) begin
      ovf_pending_q <= 1'b0;
    end
  end

  trace_mwfifo #(
    .Depth     (Depth),
    .W         (NrSlots),
    .DataWidth (RecW)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_cnt_i   (wr_cnt),
    .wr_data_i  (slot_rec),
    .free_o     (fifo_free),
    .rd_valid_o (out_valid_o),
    .rd_ready_i (out_ready_i),
    .rd_data_o  (rd_data)
  );

  assign out_record_o = trace_record_t'(rd_data);
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer using a record scoreboard.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 16;
  localparam int DCW   = 8;

  logic                     clk;
  logic                     rst;
  logic [1:0]               mode;
  logic [NP-1:0]            commit_ack;
  logic [NP-1:0][VLEN-1:0]  commit_pc;
  logic [NP-1:0][31:0]      commit_instr;
  logic [NP-1:0]            we_gpr;
  logic [NP-1:0]            we_fpr;
  logic [NP-1:0][4:0]       waddr;
  logic [NP-1:0][XLEN-1:0]  wdata;
  logic [1:0]               priv;
  logic                     debug;
  logic                     ex_valid;
  logic [XLEN-1:0]          ex_cause;
  logic [XLEN-1:0]          ex_tval;
  logic [VLEN-1:0]          ex_pc;
  logic                     out_valid;
  logic                     out_ready;
  trace_record_t            out_record;
  logic [DCW-1:0]           drop_cnt;
  logic                     clear_drop;

  commit_trace_buffer #(
    .NrCommitPorts (NP),
    .Depth         (DEPTH),
    .TsWidth       (32),
    .DropCntWidth  (DCW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mode_i         (mode),
    .commit_ack_i   (commit_ack),
    .commit_pc_i    (commit_pc),
    .commit_instr_i (commit_instr),
    .we_gpr_i       (we_gpr),
    .we_fpr_i       (we_fpr),
    .waddr_i        (waddr),
    .wdata_i        (wdata),
    .priv_lvl_i     (priv),
    .debug_mode_i   (debug),
    .ex_valid_i     (ex_valid),
    .ex_cause_i     (ex_cause),
    .ex_tval_i      (ex_tval),
    .ex_pc_i        (ex_pc),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_record_o   (out_record),
    .drop_cnt_o     (drop_cnt),
    .clear_drop_i   (clear_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            passed = 0;
  int            failed = 0;
  trace_record_t exp_q[$];
  logic [31:0]   model_ts = '0;
  int            model_drop = 0;
  bit            model_ovf = 1'b0;
  int            pops_seen = 0;
  int            pops_mark = 0;

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    commit_ack = '0;
    we_gpr     = '0;
    we_fpr     = '0;
    ex_valid   = 1'b0;
    clear_drop = 1'b0;
  endtask

  task automatic set_commit(input int k, input logic [63:0] pc, input logic [31:0] ins,
                            input logic gpr, input logic fpr, input logic [4:0] rd,
                            input logic [63:0] wd);
    commit_ack[k]   = 1'b1;
    commit_pc[k]    = pc;
    commit_instr[k] = ins;
    we_gpr[k]       = gpr;
    we_fpr[k]       = fpr;
    waddr[k]        = rd;
    wdata[k]        = wd;
  endtask

  task automatic set_exc(input logic [63:0] cause, input logic [63:0] tval, input logic [63:0] pc);
    ex_valid = 1'b1;
    ex_cause = cause;
    ex_tval  = tval;
    ex_pc    = pc;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the reference model, then step past the edge.
  task automatic apply_stimulus();
    trace_record_t b[3];
    trace_record_t r;
    int            n;
    bit            ie;
    bit            xe;
    int            free;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      model_ts   = '0;
      model_drop = 0;
      model_ovf  = 1'b0;
    end else begin
      check_output("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check_output("head_record", 256'(out_record), 256'(exp_q[0]));
      end
      check_output("drop_cnt", 256'(drop_cnt), 256'(model_drop));
      ie = (mode == 2'd1) || (mode == 2'd3 && !debug);
      xe = (mode == 2'd1) || (mode == 2'd2) || (mode == 2'd3 && !debug);
      n = 0;
      for (int k = 0; k < NP; k++) begin
        if (ie && commit_ack[k]) begin
          r       = '0;
          r.kind  = INSTR;
          r.pc    = commit_pc[k];
          r.instr = commit_instr[k];
          r.we    = we_gpr[k] | we_fpr[k];
          r.fpr   = we_fpr[k];
          r.rd    = r.we ? waddr[k] : 5'd0;
          r.wdata = r.we ? wdata[k] : 64'd0;
          r.priv  = priv;
          r.ts    = model_ts;
          b[n]    = r;
          n++;
        end
      end
      if (xe && ex_valid) begin
        r       = '0;
        r.kind  = EXC;
        r.pc    = ex_pc;
        r.instr = {ex_cause[63], 25'd0, ex_cause[5:0]};
        r.wdata = ex_tval;
        r.priv  = priv;
        r.ts    = model_ts;
        b[n]    = r;
        n++;
      end
      free = DEPTH - exp_q.size();
      if (out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pops_seen++;
      end
      if (n > 0 && n <= free) begin
        for (int i = 0; i < n; i++) begin
          r = b[i];
          if (i == 0) r.ovf = model_ovf;
          exp_q.push_back(r);
        end
        model_ovf = 1'b0;
      end else if (n > 0) begin
        model_ovf  = 1'b1;
        model_drop = clear_drop ? 1 : ((model_drop == 255) ? 255 : model_drop + 1);
      end else if (clear_drop) begin
        model_drop = 0;
      end
      if (n > free && clear_drop) model_drop = 1;
      if (n <= free && clear_drop) model_drop = 0;
      model_ts = model_ts + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    while (exp_q.size() != 0) apply_stimulus();
    apply_stimulus();
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'd1;
    out_ready = 1'b1;
    priv      = 2'd3;
    debug     = 1'b0;
    commit_pc = '0;
    commit_instr = '0;
    waddr     = '0;
    wdata     = '0;
    ex_cause  = '0;
    ex_tval   = '0;
    ex_pc     = '0;
    idle_inputs();
    apply_stimulus();
    apply_stimulus();
    rst = 1'b0;
    $display("[TB] reset values");
    check_output("reset_valid", 256'(out_valid), 256'(0));
    check_output("reset_record", 256'(out_record), 256'(0));
    check_output("reset_drop", 256'(drop_cnt), 256'(0));
    apply_stimulus();

    $display("[TB] two commits in one cycle");
    set_commit(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 64'h0);
    set_commit(1, 64'h8000_0004, 32'h0110_0293, 1'b1, 1'b0, 5'd5, 64'h11);
    apply_stimulus();
    idle_inputs();
    check_output("t1_first_pc", 256'(out_record.pc), 256'(64'h8000_0000));
    drain();

    $display("[TB] two commits plus exception");
    set_commit(0, 64'h8000_0010, 32'h0000_0013, 1'b0, 1'b1, 5'd3, 64'h55);
    set_commit(1, 64'h8000_0014, 32'h0020_8093, 1'b0, 1'b0, 5'd7, 64'h77);
    set_exc(64'd2, 64'hdead, 64'h8000_0014);
    apply_stimulus();
    drain();

    $display("[TB] overflow and drop");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_commit(0, 64'h8000_1000 + 64'(c * 8), 32'h13, 1'b1, 1'b0, 5'd1, 64'(c));
      set_commit(1, 64'h8000_1004 + 64'(c * 8), 32'h13, 1'b0, 1'b0, 5'd2, 64'hff);
      set_exc(64'h8000_0000_0000_0007, 64'(c), 64'h8000_1004);
      apply_stimulus();
    end
    apply_stimulus();
    idle_inputs();
    apply_stimulus();
    check_output("drop_once", 256'(drop_cnt), 256'(1));
    set_commit(0, 64'h8000_2000, 32'h13, 1'b0, 1'b0, 5'd0, 64'h0);
    apply_stimulus();
    apply_stimulus();
    idle_inputs();
    apply_stimulus();
    check_output("full_no_event_no_drop", 256'(drop_cnt), 256'(2));
    drain();
    set_commit(0, 64'h8000_3000, 32'h13, 1'b1, 1'b0, 5'd9, 64'h99);
    apply_stimulus();
    idle_inputs();
    check_output("ovf_set", 256'(out_record.ovf), 256'(1));
    set_commit(0, 64'h8000_3004, 32'h13, 1'b0, 1'b0, 5'd0, 64'h0);
    apply_stimulus();
    drain();

    $display("[TB] mode filtering");
    pops_mark = pops_seen;
    mode = 2'd2;
    for (int c = 0; c < 50; c++) begin
      idle_inputs();
      set_commit(0, 64'h9000_0000 + 64'(c * 8), 32'h13, 1'b1, 1'b0, 5'd4, 64'(c));
      set_commit(1, 64'h9000_0004 + 64'(c * 8), 32'h13, 1'b1, 1'b0, 5'd6, 64'(c));
      if (c == 20) set_exc(64'd11, 64'h0, 64'h9000_00a0);
      apply_stimulus();
    end
    drain();
    check_output("exc_only_count", 256'(pops_seen - pops_mark), 256'(1));
    pops_mark = pops_seen;
    mode  = 2'd3;
    debug = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_commit(0, 64'ha000_0000, 32'h13, 1'b0, 1'b0, 5'd0, 64'h0);
      set_exc(64'd3, 64'h1, 64'ha000_0000);
      apply_stimulus();
    end
    mode  = 2'd0;
    debug = 1'b0;
    apply_stimulus();
    drain();
    check_output("no_debug_off_count", 256'(pops_seen - pops_mark), 256'(0));
    mode = 2'd3;
    set_commit(1, 64'ha000_0100, 32'h13, 1'b1, 1'b0, 5'd8, 64'h88);
    apply_stimulus();
    drain();

    $display("[TB] drop counter saturation");
    mode      = 2'd1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_commit(0, 64'hb000_0000, 32'h13, 1'b0, 1'b0, 5'd0, 64'h0);
      set_commit(1, 64'hb000_0004, 32'h13, 1'b0, 1'b0, 5'd0, 64'h0);
      set_exc(64'd1, 64'h2, 64'hb000_0004);
      apply_stimulus();
    end
    idle_inputs();
    set_commit(0, 64'hb000_0100, 32'h13, 1'b0, 1'b0, 5'd0, 64'h0);
    for (int c = 0; c < 262; c++) apply_stimulus();
    check_output("drop_saturated", 256'(drop_cnt), 256'(8'hff));
    clear_drop = 1'b1;
    apply_stimulus();
    check_output("clear_with_drop", 256'(drop_cnt), 256'(1));
    idle_inputs();
    clear_drop = 1'b1;
    apply_stimulus();
    check_output("clear_alone", 256'(drop_cnt), 256'(0));
    drain();

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_commit(0, 64'hc000_0000, 32'h13, 1'b1, 1'b0, 5'd1, 64'h1);
      set_commit(1, 64'hc000_0004, 32'h13, 1'b1, 1'b0, 5'd2, 64'h2);
      apply_stimulus();
    end
    idle_inputs();
    rst = 1'b1;
    apply_stimulus();
    rst = 1'b0;
    check_output("post_reset_valid", 256'(out_valid), 256'(0));
    check_output("post_reset_record", 256'(out_record), 256'(0));
    out_ready = 1'b1;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    set_commit(0, 64'hc000_1000, 32'h13, 1'b0, 1'b0, 5'd0, 64'h0);
    apply_stimulus();
    idle_inputs();
    check_output("post_reset_ts", 256'(out_record.ts), 256'(3));
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
